pin_change_monitor: RTL and testbench
=====================================

PIN_CHANGE_MONITOR -- requirements
Module: pin_change_monitor

Interface
REQ-001 Parameter PIN_MAX, default 32: width of the monitored pin vector; equals the pin interface width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, range 1..255: consecutive identical synchronized samples required to accept a new value.
REQ-003 Parameter FIFO_DEPTH, default 8, power of two, at least 2: event buffer entries.
REQ-004 Parameter TS_W, default 16: timestamp width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-high.
REQ-007 pins  input  PIN_MAX  raw pin vector, asynchronous to clk.
REQ-008 evt_valid  output  1  event available at the head of the FIFO.
REQ-009 evt_ready  input  1  consumer accepts the head event.
REQ-010 evt_pins  output  PIN_MAX  new settled pin value.
REQ-011 evt_rise  output  PIN_MAX  per-bit 0->1 mask.
REQ-012 evt_fall  output  PIN_MAX  per-bit 1->0 mask.
REQ-013 evt_ts  output  TS_W  timestamp at acceptance.
REQ-014 overflow  output  1  sticky flag: at least one event was dropped.
REQ-015 drop_cnt  output  8  number of dropped events; saturates at 255.

Function
REQ-016 pins SHALL pass through a 2-flop synchronizer; downstream logic uses only the second flop (sync).
REQ-017 A free-running TS_W counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-018 FSM states SHALL be INIT, IDLE and SETTLE.
REQ-019 INIT: sync must equal its previous-cycle value for DEBOUNCE_CYCLES consecutive cycles; it is then loaded into stable with no event, and the FSM enters IDLE.
REQ-020 IDLE: when sync != stable, record cand = sync, clear cnt, and enter SETTLE.
REQ-021 SETTLE: when sync == cand, cnt increments; when sync != cand, cand = sync and cnt clears.
REQ-022 SETTLE: if sync == stable, return to IDLE with no event (glitch rejected).
REQ-023 SETTLE acceptance: on the edge where cnt reaches DEBOUNCE_CYCLES-1 with sync == cand, the FSM writes stable = cand, pushes an event, and enters IDLE.
REQ-024 Event contents: evt_pins = cand; evt_rise = cand & ~old stable; evt_fall = ~cand & old stable; evt_ts = counter value at acceptance.
REQ-025 Latency: a pin change first sampled at edge N SHALL give evt_valid = 1 after edge N+DEBOUNCE_CYCLES+2, provided the FIFO is empty and the pins stay steady.
REQ-026 Handshake: a pop SHALL occur only on an edge with evt_valid & evt_ready.
REQ-027 While evt_valid = 1 and no pop occurs, the evt_* outputs SHALL hold steady.
REQ-028 Full FIFO with a push and no pop on the same edge: the event is dropped, overflow is set, and drop_cnt increments.
REQ-029 Full FIFO with a push and a pop on the same edge: both complete; no drop.
REQ-030 Empty FIFO: evt_valid = 0; a push is visible on evt_* the cycle after it is written (no bypass).

Reset
REQ-031 Reset values: sync flops 0; stable 0; cand 0; cnt 0; timestamp 0; FSM state INIT.
REQ-032 Reset values: FIFO empty; evt_valid 0; evt_pins, evt_rise, evt_fall and evt_ts all 0; overflow 0; drop_cnt 0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight settling and all buffered events; the pins are re-baselined through INIT with no spurious event.

Structure
REQ-034 Package pin_mon_pkg SHALL hold the FSM state enum and a parameterized event struct {pins, rise, fall, ts}.
REQ-035 The FIFO SHALL be the sub-module pin_mon_fifo: synchronous, with full/empty flags, a single clock and async reset.

Verification (DEBOUNCE_CYCLES = 4, PIN_MAX = 8)
REQ-036 Reset with pins = 0xA5, held for 10 cycles -> no event; stable = 0xA5.
REQ-037 From baseline 0x00, pins -> 0x03 held -> exactly one event 7 cycles later: pins 0x03, rise 0x03, fall 0x00.
REQ-038 Pin 0 pulsed high for 2 cycles from 0x00 -> no event.
REQ-039 evt_ready = 0 and 9 alternating changes 0x00/0xFF, each held 10 cycles -> 8 events buffered; overflow = 1; drop_cnt = 1; the first popped event is pins 0xFF.
REQ-040 FIFO full with evt_ready = 1 and a push on the same edge -> no drop; occupancy stays 8.
REQ-041 rst asserted during SETTLE toward 0x0F, then released with pins at 0x0F -> no event; baseline = 0x0F.

Source files
------------

// File: rtl/pin_mon_pkg.sv
// Shared types and constants for the pin change monitor.
package pin_mon_pkg;

  // Width of the saturating drop counter exposed on the drop_cnt port.
  localparam int DROP_CNT_W = 8;

  // Width of the debounce counter; covers DEBOUNCE_CYCLES up to 255.
  localparam int DEB_CNT_W = 8;

  // Debounce controller states.
  typedef enum logic [1:0] {
    INIT,
    IDLE,
    SETTLE
  } state_t;

  // Event record carried through the FIFO. The class wrapper lets the struct
  // take the module's PIN_MAX/TS_W, which a plain package typedef cannot do.
  class evt_types #(parameter int PIN_W = 32, parameter int T_W = 16);
    typedef struct packed {
      logic [PIN_W-1:0] pins;
      logic [PIN_W-1:0] rise;
      logic [PIN_W-1:0] fall;
      logic [T_W-1:0]   ts;
    } evt_t;
  endclass

endpackage

// File: rtl/pin_mon_fifo.sv
// Synchronous event FIFO with full/empty flags; head visible on rd_data.
module pin_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a write
  // when it is also being read.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Storage write.
  // NOTE: the array has no reset; contents are only observed through rd_ptr
  // once count says the slot is valid, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pin_change_monitor.sv
// Debounces an asynchronous pin vector and queues timestamped change events.
module pin_change_monitor
  import pin_mon_pkg::*;
#(
  parameter int PIN_MAX         = 32,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int TS_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIN_MAX-1:0]    pins,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [PIN_MAX-1:0]    evt_pins,
  output logic [PIN_MAX-1:0]    evt_rise,
  output logic [PIN_MAX-1:0]    evt_fall,
  output logic [TS_W-1:0]       evt_ts,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef evt_types#(PIN_MAX, TS_W)::evt_t evt_t;

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [PIN_MAX-1:0]   sync1, sync, sync_prev;
  logic [PIN_MAX-1:0]   stable, stable_nxt;
  logic [PIN_MAX-1:0]   cand, cand_nxt;
  logic [DEB_CNT_W-1:0] cnt, cnt_nxt;
  logic [TS_W-1:0]      ts;
  state_t               state, state_nxt;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  evt_t                 push_evt;
  evt_t                 head_raw;
  evt_t                 head;

  // Two-flop synchronizer; only sync feeds the rest of the design.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= pins;
      sync  <= sync1;
    end
  end

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      stable    <= '0;
      cand      <= '0;
      cnt       <= '0;
      sync_prev <= '0;
    end else begin
      state     <= state_nxt;
      stable    <= stable_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      sync_prev <= sync;
    end
  end

  // Debounce next-state logic and event push decision.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    stable_nxt = stable;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    push       = 1'b0;
    unique case (state)
      INIT: begin
        if (sync == sync_prev) begin
          if (cnt == CNT_LAST) begin
            stable_nxt = sync;
            cnt_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      IDLE: begin
        if (sync != stable) begin
          cand_nxt  = sync;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (sync == stable) begin
          // Pins went back to the settled value: a glitch, no event.
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (sync != cand) begin
          cand_nxt = sync;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          stable_nxt = cand;
          cnt_nxt    = '0;
          push       = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign push_evt.pins = cand;
  assign push_evt.rise = cand & ~stable;
  assign push_evt.fall = ~cand & stable;
  assign push_evt.ts   = ts;

  assign pop  = evt_valid && evt_ready;
  assign drop = push && fifo_full && !pop;

  pin_mon_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_evt),
    .rd_en   (pop),
    .rd_data (head_raw),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Outputs read as zero whenever nothing is queued, including after reset.
  assign head      = fifo_empty ? '0 : head_raw;
  assign evt_valid = !fifo_empty;
  assign evt_pins  = head.pins;
  assign evt_rise  = head.rise;
  assign evt_fall  = head.fall;
  assign evt_ts    = head.ts;

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pin_change_monitor.sv
// Self-checking bench: table-driven changes plus hand-written corner cases,
// with a queue of expected events compared at each pop.
module tb_pin_change_monitor;

  localparam int PIN_MAX = 8;
  localparam int DEB     = 4;
  localparam int DEPTH   = 8;
  localparam int TS_W    = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [PIN_MAX-1:0] pins;
  logic               evt_valid;
  logic               evt_ready;
  logic [PIN_MAX-1:0] evt_pins;
  logic [PIN_MAX-1:0] evt_rise;
  logic [PIN_MAX-1:0] evt_fall;
  logic [TS_W-1:0]    evt_ts;
  logic               overflow;
  logic [7:0]         drop_cnt;

  always #5 clk = ~clk;

  pin_change_monitor #(
    .PIN_MAX         (PIN_MAX),
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH),
    .TS_W            (TS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pins      (pins),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_pins  (evt_pins),
    .evt_rise  (evt_rise),
    .evt_fall  (evt_fall),
    .evt_ts    (evt_ts),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic [7:0]  pins;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic [15:0] ts;
  } exp_t;

  typedef struct {
    logic [7:0] pins;
    int         hold;
    bit         evt;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] ts_model;
  logic [7:0]  base;

  // Reference timestamp: zero in reset, +1 per edge.
  always @(posedge clk or posedge rst) begin
    if (rst) ts_model <= '0;
    else     ts_model <= ts_model + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Compare the head if it is being popped this cycle, then advance one clock
  // and return #2 after the falling edge.
  task automatic tick();
    exp_t e;
    if (evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got pins %0h, required no event", evt_pins);
      end else begin
        e = sb.pop_front();
        check("evt_pins", 32'(evt_pins), 32'(e.pins));
        check("evt_rise", 32'(evt_rise), 32'(e.rise));
        check("evt_fall", 32'(evt_fall), 32'(e.fall));
        check("evt_ts",   32'(evt_ts),   32'(e.ts));
      end
    end
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  // Drive a new pin value; when an event is expected, its acceptance edge is
  // DEB+3 edges away, so the timestamp is the current count plus DEB+2.
  task automatic change(input logic [7:0] np, input bit expect_evt);
    exp_t e;
    pins = np;
    if (expect_evt) begin
      e.pins = np;
      e.rise = np & ~base;
      e.fall = ~np & base;
      e.ts   = ts_model + 16'(DEB + 2);
      sb.push_back(e);
    end
    base = np;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'hA4, 12, 1'b1, 8'h00, 8'h01};
    vecs[1]  = '{8'h00, 12, 1'b1, 8'h00, 8'hA4};
    vecs[2]  = '{8'h03, 12, 1'b1, 8'h03, 8'h00};
    vecs[3]  = '{8'h02,  2, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{8'h03, 12, 1'b0, 8'h00, 8'h00};
    vecs[5]  = '{8'h3C, 12, 1'b1, 8'h3C, 8'h03};
    vecs[6]  = '{8'hC3, 12, 1'b1, 8'hC3, 8'h3C};
    vecs[7]  = '{8'h10,  3, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{8'h20, 12, 1'b1, 8'h20, 8'hC3};
    vecs[9]  = '{8'h21,  1, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{8'h20, 12, 1'b0, 8'h00, 8'h00};

    // Reset values, with the pins already at 0xA5.
    rst       = 1'b1;
    pins      = 8'hA5;
    evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_pins",  32'(evt_pins),  32'd0);
    check("rst_evt_rise",  32'(evt_rise),  32'd0);
    check("rst_evt_fall",  32'(evt_fall),  32'd0);
    check("rst_evt_ts",    32'(evt_ts),    32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    rst  = 1'b0;
    base = 8'hA5;

    // Baseline through INIT: no event.
    repeat (10) tick();
    check("init_no_event", 32'(evt_valid), 32'd0);

    // Table of changes from baseline 0xA5 with the consumer always ready.
    evt_ready = 1'b1;
    foreach (vecs[i]) begin
      pins = vecs[i].pins;
      if (vecs[i].evt)
        sb.push_back('{vecs[i].pins, vecs[i].rise, vecs[i].fall, ts_model + 16'(DEB + 2)});
      repeat (vecs[i].hold) tick();
    end
    base = 8'h20;
    drain("table_all_events");

    // Exact latency: valid rises after the seventh edge from the drive.
    evt_ready = 1'b0;
    change(8'h00, 1'b1);
    repeat (DEB + 2) tick();
    check("latency_early", 32'(evt_valid), 32'd0);
    tick();
    check("latency_on_time", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    drain("latency_event");

    // Nine events into an eight-entry FIFO with no consumer: one dropped.
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      change((i % 2 == 0) ? 8'hFF : 8'h00, i < DEPTH);
      repeat (10) tick();
    end
    check("ovf_flag",     32'(overflow),  32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt),  32'd1);
    check("ovf_valid",    32'(evt_valid), 32'd1);
    check("ovf_head",     32'(evt_pins),  32'hFF);

    // Full FIFO: a push and a pop on the same edge both complete.
    change(8'h00, 1'b1);
    repeat (DEB + 2) tick();
    evt_ready = 1'b1;
    tick();
    check("simul_no_drop", 32'(drop_cnt), 32'd1);
    check("simul_ovf",     32'(overflow), 32'd1);
    drain("simul_all_events");
    repeat (2) tick();
    check("drained_valid", 32'(evt_valid), 32'd0);

    // Reset mid-settle with one event buffered: all of it is discarded.
    evt_ready = 1'b0;
    change(8'h55, 1'b1);
    repeat (10) tick();
    change(8'h0F, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    sb.delete();
    repeat (2) tick();
    check("midrst_valid",    32'(evt_valid), 32'd0);
    check("midrst_pins",     32'(evt_pins),  32'd0);
    check("midrst_overflow", 32'(overflow),  32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt),  32'd0);
    rst       = 1'b0;
    base      = 8'h0F;
    evt_ready = 1'b1;
    repeat (15) tick();
    check("postrst_no_event", 32'(evt_valid), 32'd0);

    // Baseline after reset must be 0x0F: clearing bit 0 is a pure fall.
    change(8'h0E, 1'b1);
    repeat (10) tick();
    drain("rebaseline_event");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
